// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if
//   Signal bundle between the ID/EX register, the MEM/WB feedback path,
//   the hazard consumers and the EX/MEM register of ex_mem_stage.
//
//   ID/EX side   : i_WB, i_M, i_EX, i_Rs, i_Rt, i_Rd, i_imm16, i_BusA, i_BusB
//   MEM/WB side  : wb_RegWr, wb_Rw, wb_data
//   IF/ID side   : id_Rs, id_Rt
//   Control      : stall, flush
//   Hazard       : load_used
//   EX/MEM side  : o_WB, o_M, o_Rw, o_ALUout, o_BusB, o_ovf
//
//   slave  : the execute stage (consumes i_*, wb_*, id_*, stall, flush)
//   master : the surrounding pipeline (drives those, receives o_*/load_used)
interface ex_mem_stage_if;
  logic [1:0]  i_WB;
  logic        i_M;
  logic [5:0]  i_EX;
  logic [4:0]  i_Rs;
  logic [4:0]  i_Rt;
  logic [4:0]  i_Rd;
  logic [15:0] i_imm16;
  logic [31:0] i_BusA;
  logic [31:0] i_BusB;
  logic        wb_RegWr;
  logic [4:0]  wb_Rw;
  logic [31:0] wb_data;
  logic [4:0]  id_Rs;
  logic [4:0]  id_Rt;
  logic        stall;
  logic        flush;
  logic        load_used;
  logic [1:0]  o_WB;
  logic        o_M;
  logic [4:0]  o_Rw;
  logic [31:0] o_ALUout;
  logic [31:0] o_BusB;
  logic        o_ovf;

  modport master (
    output i_WB, i_M, i_EX, i_Rs, i_Rt, i_Rd, i_imm16, i_BusA, i_BusB,
    output wb_RegWr, wb_Rw, wb_data, id_Rs, id_Rt, stall, flush,
    input  load_used, o_WB, o_M, o_Rw, o_ALUout, o_BusB, o_ovf
  );

  modport slave (
    input  i_WB, i_M, i_EX, i_Rs, i_Rt, i_Rd, i_imm16, i_BusA, i_BusB,
    input  wb_RegWr, wb_Rw, wb_data, id_Rs, id_Rt, stall, flush,
    output load_used, o_WB, o_M, o_Rw, o_ALUout, o_BusB, o_ovf
  );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   Execute stage plus the EX/MEM pipeline register. Selects (optionally
//   forwarded) operands, extends imm16, runs the ALU, picks the destination
//   register and latches everything into EX/MEM on the falling clock edge.
//   Also raises the combinational load-use hazard for the upstream stages.
//
//   Ports
//     clk  : pipeline clock, state updates on the falling edge
//     rst  : synchronous active-high reset, sampled at the falling edge
//     bus  : ex_mem_stage_if.slave (ID/EX inputs, MEM/WB feedback, IF/ID
//            register fields, stall/flush, load_used, EX/MEM outputs)
//
//   Parameter
//     OVF_SQUASH : 1 = signed add/sub overflow clears the registered RegWr,
//                  0 = overflow is only flagged on o_ovf
//
//   Build option
//     EX_FWD_EN  : when defined, EX/MEM and MEM/WB forwarding plus the
//                  load-use detector are built; when undefined the operands
//                  come straight from i_BusA/i_BusB and load_used is 0.
module ex_mem_stage #(
  parameter int OVF_SQUASH = 1
) (
  input  logic        clk,
  input  logic        rst,
  ex_mem_stage_if.slave bus
);

  // EX/MEM register contents; power-up values match the reset values.
  logic [1:0]         wb_p1   = 2'b00;
  logic               m_p1    = 1'b0;
  logic [4:0]         rw_p1   = 5'd0;
  logic signed [31:0] alu_p1  = 32'sd0;
  logic signed [31:0] busb_p1 = 32'sd0;
  logic               ovf_p1  = 1'b0;

  logic               ext_op_p0;
  logic               alu_src_p0;
  logic [2:0]         alu_ctr_p0;
  logic               reg_dst_p0;
  logic signed [31:0] op_a_p0;
  logic signed [31:0] op_b_p0;
  logic signed [31:0] imm_ext_p0;
  logic signed [31:0] alu_in_b_p0;
  logic signed [31:0] alu_res_p0;
  logic               ovf_p0;
  logic [4:0]         rw_p0;
  logic               reg_wr_p0;

  function automatic logic signed [31:0] alu_calc(
    input logic [2:0]         ctr,
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input logic [15:0]        imm
  );
    logic signed [31:0] r;
    case (ctr)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = (a < b) ? 32'sd1 : 32'sd0;
      3'b110:  r = ($unsigned(a) < $unsigned(b)) ? 32'sd1 : 32'sd0;
      default: r = $signed({imm, 16'h0000});
    endcase
    return r;
  endfunction

  // Two's-complement overflow: operands agree in sign (add) or differ
  // (sub) and the result sign departs from operand a.
  function automatic logic addsub_ovf(
    input logic [2:0]         ctr,
    input logic signed [31:0] a,
    input logic signed [31:0] b,
    input logic signed [31:0] r
  );
    logic o;
    case (ctr)
      3'b000:  o = (a[31] == b[31]) && (r[31] != a[31]);
      3'b001:  o = (a[31] != b[31]) && (r[31] != a[31]);
      default: o = 1'b0;
    endcase
    return o;
  endfunction

  assign ext_op_p0  = bus.i_EX[5];
  assign alu_src_p0 = bus.i_EX[4];
  assign alu_ctr_p0 = bus.i_EX[3:1];
  assign reg_dst_p0 = bus.i_EX[0];

`ifdef EX_FWD_EN
  logic exm_ok_p0;
  logic wbk_ok_p0;

  // Register $0 never matches; EX/MEM is checked before MEM/WB so the
  // younger producer wins.
  function automatic logic signed [31:0] fwd_sel(
    input logic [4:0]         src,
    input logic signed [31:0] reg_val,
    input logic               exm_ok,
    input logic [4:0]         exm_rw,
    input logic signed [31:0] exm_val,
    input logic               wbk_ok,
    input logic [4:0]         wbk_rw,
    input logic signed [31:0] wbk_val
  );
    logic signed [31:0] v;
    v = reg_val;
    if (src != 5'd0) begin
      if (exm_ok && (exm_rw == src))
        v = exm_val;
      else if (wbk_ok && (wbk_rw == src))
        v = wbk_val;
    end
    return v;
  endfunction

  // A load sitting in EX/MEM has no data yet; the load-use stall covers it.
  assign exm_ok_p0 = wb_p1[0] && !wb_p1[1];
  assign wbk_ok_p0 = bus.wb_RegWr;

  assign op_a_p0 = fwd_sel(bus.i_Rs, $signed(bus.i_BusA), exm_ok_p0, rw_p1,
                           alu_p1, wbk_ok_p0, bus.wb_Rw, $signed(bus.wb_data));
  assign op_b_p0 = fwd_sel(bus.i_Rt, $signed(bus.i_BusB), exm_ok_p0, rw_p1,
                           alu_p1, wbk_ok_p0, bus.wb_Rw, $signed(bus.wb_data));

  assign bus.load_used = (bus.i_WB == 2'b11) && (bus.i_Rt != 5'd0) &&
                         ((bus.i_Rt == bus.id_Rs) || (bus.i_Rt == bus.id_Rt));
`else
  logic unused_fwd;

  assign op_a_p0       = $signed(bus.i_BusA);
  assign op_b_p0       = $signed(bus.i_BusB);
  assign bus.load_used = 1'b0;
  assign unused_fwd    = ^{bus.i_Rs, bus.wb_RegWr, bus.wb_Rw, bus.wb_data,
                           bus.id_Rs, bus.id_Rt};
`endif

  assign imm_ext_p0  = ext_op_p0 ? $signed({{16{bus.i_imm16[15]}}, bus.i_imm16})
                                 : $signed({16'h0000, bus.i_imm16});
  assign alu_in_b_p0 = alu_src_p0 ? imm_ext_p0 : op_b_p0;
  assign alu_res_p0  = alu_calc(alu_ctr_p0, op_a_p0, alu_in_b_p0, bus.i_imm16);
  assign ovf_p0      = addsub_ovf(alu_ctr_p0, op_a_p0, alu_in_b_p0, alu_res_p0);
  assign rw_p0       = reg_dst_p0 ? bus.i_Rd : bus.i_Rt;
  assign reg_wr_p0   = bus.i_WB[0] && !((OVF_SQUASH != 0) && ovf_p0);

  // ---- EX -> EX/MEM boundary (falling edge) ----
  always_ff @(negedge clk) begin
    if (rst) begin
      wb_p1   <= 2'b00;
      m_p1    <= 1'b0;
      rw_p1   <= 5'd0;
      alu_p1  <= 32'sd0;
      busb_p1 <= 32'sd0;
      ovf_p1  <= 1'b0;
    end else if (!bus.stall) begin
      rw_p1   <= rw_p0;
      alu_p1  <= alu_res_p0;
      busb_p1 <= op_b_p0;
      if (bus.flush) begin
        wb_p1  <= 2'b00;
        m_p1   <= 1'b0;
        ovf_p1 <= 1'b0;
      end else begin
        wb_p1  <= {bus.i_WB[1], reg_wr_p0};
        m_p1   <= bus.i_M;
        ovf_p1 <= ovf_p0;
      end
    end
  end

  assign bus.o_WB     = wb_p1;
  assign bus.o_M      = m_p1;
  assign bus.o_Rw     = rw_p1;
  assign bus.o_ALUout = alu_p1;
  assign bus.o_BusB   = busb_p1;
  assign bus.o_ovf    = ovf_p1;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
//   Drives two ex_mem_stage instances (OVF_SQUASH=1 and OVF_SQUASH=0) with the
//   same stimulus and compares both against a behavioural model. Directed
//   scenarios first, then randomized traffic.
module tb_ex_mem_stage;

`ifdef EX_FWD_EN
  localparam bit USE_FWD = 1'b1;
`else
  localparam bit USE_FWD = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  wb;
    logic        m;
    logic [4:0]  rw;
    logic [31:0] alu;
    logic [31:0] busb;
    logic        ovf;
  } st_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_WB;
  logic        i_M;
  logic [5:0]  i_EX;
  logic [4:0]  i_Rs, i_Rt, i_Rd;
  logic [15:0] i_imm16;
  logic [31:0] i_BusA, i_BusB;
  logic        wb_RegWr;
  logic [4:0]  wb_Rw;
  logic [31:0] wb_data;
  logic [4:0]  id_Rs, id_Rt;
  logic        stall, flush;

  int n_chk  = 0;
  int n_fail = 0;
  st_t s1 = '0;
  st_t s0 = '0;

  ex_mem_stage_if ifs ();
  ex_mem_stage_if ifn ();

  assign ifs.i_WB = i_WB;         assign ifn.i_WB = i_WB;
  assign ifs.i_M = i_M;           assign ifn.i_M = i_M;
  assign ifs.i_EX = i_EX;         assign ifn.i_EX = i_EX;
  assign ifs.i_Rs = i_Rs;         assign ifn.i_Rs = i_Rs;
  assign ifs.i_Rt = i_Rt;         assign ifn.i_Rt = i_Rt;
  assign ifs.i_Rd = i_Rd;         assign ifn.i_Rd = i_Rd;
  assign ifs.i_imm16 = i_imm16;   assign ifn.i_imm16 = i_imm16;
  assign ifs.i_BusA = i_BusA;     assign ifn.i_BusA = i_BusA;
  assign ifs.i_BusB = i_BusB;     assign ifn.i_BusB = i_BusB;
  assign ifs.wb_RegWr = wb_RegWr; assign ifn.wb_RegWr = wb_RegWr;
  assign ifs.wb_Rw = wb_Rw;       assign ifn.wb_Rw = wb_Rw;
  assign ifs.wb_data = wb_data;   assign ifn.wb_data = wb_data;
  assign ifs.id_Rs = id_Rs;       assign ifn.id_Rs = id_Rs;
  assign ifs.id_Rt = id_Rt;       assign ifn.id_Rt = id_Rt;
  assign ifs.stall = stall;       assign ifn.stall = stall;
  assign ifs.flush = flush;       assign ifn.flush = flush;

  ex_mem_stage #(.OVF_SQUASH(1)) dut_sq (.clk(clk), .rst(rst), .bus(ifs.slave));
  ex_mem_stage #(.OVF_SQUASH(0)) dut_ns (.clk(clk), .rst(rst), .bus(ifn.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Value a consumer would read for register r, given the EX/MEM contents s.
  function automatic logic [31:0] read_reg(st_t s, logic [4:0] r, logic [31:0] file_val);
    if (!USE_FWD || r == 5'd0) return file_val;
    if (s.wb == 2'b01 && s.rw == r) return s.alu;
    if (wb_RegWr && wb_Rw == r) return wb_data;
    return file_val;
  endfunction

  function automatic logic exp_lu();
    return USE_FWD && (i_WB == 2'b11) && (i_Rt != 5'd0) &&
           ((i_Rt == id_Rs) || (i_Rt == id_Rt));
  endfunction

  function automatic st_t next_state(st_t s, bit squash);
    st_t n;
    logic [31:0] a, b, imm_x, opb, res;
    longint exact;
    bit ov;
    if (rst) return '0;
    if (stall) return s;
    a = read_reg(s, i_Rs, i_BusA);
    b = read_reg(s, i_Rt, i_BusB);
    imm_x = (i_EX[5] && i_imm16 >= 16'h8000) ? 32'(i_imm16) + 32'hFFFF0000 : 32'(i_imm16);
    opb = i_EX[4] ? imm_x : b;
    ov = 1'b0;
    exact = 0;
    case (i_EX[3:1])
      3'd0: begin
        exact = longint'($signed(a)) + longint'($signed(opb));
        res = exact[31:0];
        ov = (exact != longint'($signed(res)));
      end
      3'd1: begin
        exact = longint'($signed(a)) - longint'($signed(opb));
        res = exact[31:0];
        ov = (exact != longint'($signed(res)));
      end
      3'd2: res = a & opb;
      3'd3: res = a | opb;
      3'd4: res = a ^ opb;
      3'd5: res = (int'(a) < int'(opb)) ? 32'd1 : 32'd0;
      3'd6: res = (a < opb) ? 32'd1 : 32'd0;
      default: res = 32'(i_imm16) * 32'd65536;
    endcase
    n.alu  = res;
    n.busb = b;
    n.rw   = i_EX[0] ? i_Rd : i_Rt;
    if (flush) begin
      n.wb = 2'b00; n.m = 1'b0; n.ovf = 1'b0;
    end else begin
      n.wb = {i_WB[1], i_WB[0] && !(squash && ov)};
      n.m = i_M;
      n.ovf = ov;
    end
    return n;
  endfunction

  task automatic clr();
    rst = 1'b0; i_WB = 2'b00; i_M = 1'b0; i_EX = 6'd0;
    i_Rs = 5'd0; i_Rt = 5'd0; i_Rd = 5'd0; i_imm16 = 16'd0;
    i_BusA = 32'd0; i_BusB = 32'd0; wb_RegWr = 1'b0; wb_Rw = 5'd0;
    wb_data = 32'd0; id_Rs = 5'd0; id_Rt = 5'd0; stall = 1'b0; flush = 1'b0;
  endtask

  // Inputs are already applied; check load_used, take one falling edge,
  // then compare both instances against the model.
  task automatic cycle();
    st_t n1, n0;
    #1;
    chk("load_used", 32'(ifs.load_used), 32'(exp_lu()));
    n1 = next_state(s1, 1'b1);
    n0 = next_state(s0, 1'b0);
    @(negedge clk);
    s1 = n1;
    s0 = n0;
    #1;
    chk("sq_wb",   32'(ifs.o_WB),  32'(s1.wb));
    chk("sq_m",    32'(ifs.o_M),   32'(s1.m));
    chk("sq_rw",   32'(ifs.o_Rw),  32'(s1.rw));
    chk("sq_alu",  ifs.o_ALUout,   s1.alu);
    chk("sq_busb", ifs.o_BusB,     s1.busb);
    chk("sq_ovf",  32'(ifs.o_ovf), 32'(s1.ovf));
    chk("ns_wb",   32'(ifn.o_WB),  32'(s0.wb));
    chk("ns_alu",  ifn.o_ALUout,   s0.alu);
    chk("ns_busb", ifn.o_BusB,     s0.busb);
    chk("ns_ovf",  32'(ifn.o_ovf), 32'(s0.ovf));
  endtask

  initial begin
    clr();
    i_BusA = $urandom; i_BusB = $urandom; i_WB = 2'b11; i_M = 1'b1; i_Rd = 5'd9;
    #1;
    chk("pwr_wb",  32'(ifs.o_WB), 32'd0);
    chk("pwr_alu", ifs.o_ALUout,  32'd0);
    chk("pwr_ovf", 32'(ifs.o_ovf), 32'd0);

    // Reset for two edges with arbitrary inputs.
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_wb",  32'(ifs.o_WB), 32'd0);
    chk("rst_alu", ifs.o_ALUout,  32'd0);
    chk("rst_m",   32'(ifs.o_M),  32'd0);

    // First instruction after reset: add 5+7 -> $3.
    clr();
    i_EX = 6'b000001; i_BusA = 32'd5; i_BusB = 32'd7; i_Rs = 5'd1; i_Rt = 5'd2;
    i_Rd = 5'd3; i_WB = 2'b01;
    cycle();
    chk("first_alu", ifs.o_ALUout, 32'd12);
    chk("first_rw",  32'(ifs.o_Rw), 32'd3);
    chk("first_wb",  32'(ifs.o_WB), 32'd1);

    // $4 = 0x10, then a reader of $4 with stale BusA while MEM/WB also has $4.
    i_BusA = 32'd8; i_BusB = 32'd8; i_Rd = 5'd4;
    cycle();
    clr();
    i_EX = 6'b000001; i_Rs = 5'd4; i_Rt = 5'd0; i_Rd = 5'd5; i_WB = 2'b01;
    wb_RegWr = 1'b1; wb_Rw = 5'd4; wb_data = 32'h99;
    cycle();
    chk("fwd_prio", ifs.o_ALUout, USE_FWD ? 32'h10 : 32'h0);

    // Load-use detection, and $0 never hazards.
    clr();
    i_WB = 2'b11; i_Rt = 5'd8; id_Rs = 5'd8;
    #1;
    chk("lu_hit", 32'(ifs.load_used), USE_FWD ? 32'd1 : 32'd0);
    cycle();
    i_Rt = 5'd0; id_Rs = 5'd0;
    #1;
    chk("lu_r0", 32'(ifs.load_used), 32'd0);
    cycle();

    // Signed overflow on add.
    clr();
    i_EX = 6'b000001; i_Rs = 5'd10; i_Rt = 5'd11; i_Rd = 5'd12; i_WB = 2'b01;
    i_BusA = 32'h7FFFFFFF; i_BusB = 32'd1;
    cycle();
    chk("ovf_flag",  32'(ifs.o_ovf), 32'd1);
    chk("ovf_sq_rw", 32'(ifs.o_WB[0]), 32'd0);
    chk("ovf_alu",   ifs.o_ALUout, 32'h80000000);
    chk("ovf_ns_rw", 32'(ifn.o_WB[0]), 32'd1);

    // stall+flush holds; flush alone bubbles control, loads data.
    clr();
    i_EX = 6'b000001; i_Rs = 5'd13; i_Rt = 5'd14; i_Rd = 5'd15; i_WB = 2'b01; i_M = 1'b1;
    i_BusA = 32'd2; i_BusB = 32'd3; stall = 1'b1; flush = 1'b1;
    cycle();
    chk("stall_alu", ifs.o_ALUout, 32'h80000000);
    chk("stall_ovf", 32'(ifs.o_ovf), 32'd1);
    stall = 1'b0;
    cycle();
    chk("flush_wb",  32'(ifs.o_WB), 32'd0);
    chk("flush_m",   32'(ifs.o_M),  32'd0);
    chk("flush_alu", ifs.o_ALUout,  32'd5);

    // Immediate extension and lui.
    clr();
    i_Rs = 5'd20; i_Rt = 5'd21; i_BusA = 32'd1; i_imm16 = 16'hFFFF; i_WB = 2'b01;
    i_EX = 6'b110000;
    cycle();
    chk("sext_add", ifs.o_ALUout, 32'd0);
    i_EX = 6'b010000;
    cycle();
    chk("zext_add", ifs.o_ALUout, 32'h00010000);
    i_EX = 6'b011110;
    cycle();
    chk("lui", ifs.o_ALUout, 32'hFFFF0000);

    // Randomized traffic; small register range so hazards are common.
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 39) == 0);
      stall    = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      i_WB     = 2'($urandom);
      i_M      = 1'($urandom);
      i_EX     = 6'($urandom);
      i_Rs     = 5'($urandom_range(0, 7));
      i_Rt     = 5'($urandom_range(0, 7));
      i_Rd     = 5'($urandom_range(0, 7));
      i_imm16  = 16'($urandom);
      case ($urandom_range(0, 3))
        0: i_BusA = 32'h7FFFFFFF;
        1: i_BusA = 32'h80000000;
        default: i_BusA = $urandom;
      endcase
      i_BusB   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      wb_RegWr = 1'($urandom);
      wb_Rw    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      id_Rs    = 5'($urandom_range(0, 7));
      id_Rt    = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
